cpu_trace_monitor: RTL and testbench

Parametrised execution-trace capture block for the single-cycle CPU.
- Samples the CPU's current PC and instruction every enabled cycle into a circular buffer.
- Supports a PC-match trigger with post-trigger capture, halt detection and a cycle-count timeout.
- After capture ends, the buffer is drained oldest-first through a read port.
- Sits beside the CPU core and replaces fixed-length trace printing with a synthesizable, bounded trace of any depth.

---
 rtl/cpu_trace_monitor_if.sv | 36 +++
 rtl/cpu_trace_monitor.sv | 164 ++++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_monitor_if.sv
// rtl/cpu_trace_monitor_if.sv - control, sample and readout signals of the trace monitor
interface cpu_trace_monitor_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_WIDTH   = 16
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic                              start;
  logic                              enable;
  logic [ADDR_WIDTH-1:0]             pc;
  logic [INSTR_WIDTH-1:0]            instruction;
  logic                              trig_en;
  logic [ADDR_WIDTH-1:0]             trig_pc;
  logic                              rd_en;
  logic [ADDR_WIDTH+INSTR_WIDTH-1:0] rd_data;
  logic                              rd_valid;
  logic [FILL_W-1:0]                 fill;
  logic [CNT_WIDTH-1:0]              cycle_count;
  logic                              busy;
  logic                              done;
  logic                              triggered;
  logic                              halted;
  logic                              timed_out;

  modport master (
    output start, enable, pc, instruction, trig_en, trig_pc, rd_en,
    input  rd_data, rd_valid, fill, cycle_count, busy, done, triggered, halted, timed_out
  );

  modport slave (
    input  start, enable, pc, instruction, trig_en, trig_pc, rd_en,
    output rd_data, rd_valid, fill, cycle_count, busy, done, triggered, halted, timed_out
  );
endinterface

// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - circular execution-trace capture with trigger, halt and timeout stop
module cpu_trace_monitor #(
  parameter int                     ADDR_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     DEPTH       = 16,
  parameter int                     POST_TRIG   = 4,
  parameter int                     CNT_WIDTH   = 16,
  parameter int                     TIMEOUT     = 1000,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = 'h0000000c
) (
  input logic               clk,
  input logic               reset_n,
  cpu_trace_monitor_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int DATA_W = ADDR_WIDTH + INSTR_WIDTH;

  localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_STOP  = CNT_WIDTH'(TIMEOUT);
  localparam logic [PTR_W-1:0]     POST_LOAD = PTR_W'(POST_TRIG);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
  logic [PTR_W-1:0]       post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0]  prev_pc_q, prev_pc_d;
  logic                   prev_valid_q, prev_valid_d;
  logic                   triggered_q, triggered_d;
  logic                   halted_q, halted_d;
  logic                   timed_out_q, timed_out_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]      trace_mem [DEPTH];
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_wdata;
  logic [PTR_W-1:0]       rd_addr;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   halt_hit;
  logic                   to_hit;
  logic                   trig_hit;

  // Next-state logic: start handling, sampling with stop detection, and oldest-first readout
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    cycle_count_d = cycle_count_q;
    post_cnt_d    = post_cnt_q;
    prev_pc_d     = prev_pc_q;
    prev_valid_d  = prev_valid_q;
    triggered_d   = triggered_q;
    halted_d      = halted_q;
    timed_out_d   = timed_out_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = {bus.pc, bus.instruction};

    cnt_inc  = (cycle_count_q == CNT_MAX) ? cycle_count_q : cycle_count_q + CNT_WIDTH'(1);
    halt_hit = (bus.instruction == HALT_INSTR) || (prev_valid_q && (bus.pc == prev_pc_q));
    to_hit   = (cnt_inc == CNT_STOP);
    trig_hit = (state_q == ST_RUN) && bus.trig_en && (bus.pc == bus.trig_pc);
    // With fill==DEPTH the low bits are zero, so the oldest entry sits at wr_ptr itself.
    rd_addr  = wr_ptr_q - fill_q[PTR_W-1:0];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d       = ST_RUN;
          wr_ptr_d      = '0;
          fill_d        = '0;
          cycle_count_d = '0;
          post_cnt_d    = '0;
          prev_valid_d  = 1'b0;
          triggered_d   = 1'b0;
          halted_d      = 1'b0;
          timed_out_d   = 1'b0;
        end else if ((state_q == ST_DONE) && bus.rd_en && (fill_q != '0)) begin
          rd_data_d  = trace_mem[rd_addr];
          rd_valid_d = 1'b1;
          fill_d     = fill_q - FILL_W'(1);
        end
      end
      default: begin
        if (bus.enable) begin
          mem_we        = 1'b1;
          wr_ptr_d      = wr_ptr_q + PTR_W'(1);
          fill_d        = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
          cycle_count_d = cnt_inc;
          prev_pc_d     = bus.pc;
          prev_valid_d  = 1'b1;
          if (halt_hit) halted_d    = 1'b1;
          if (to_hit)   timed_out_d = 1'b1;
          if (trig_hit) triggered_d = 1'b1;
          // Halt and timeout end capture outright; a coincident trigger is only recorded.
          if (halt_hit || to_hit) begin
            state_d = ST_DONE;
          end else if (trig_hit) begin
            post_cnt_d = POST_LOAD;
            state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
          end else if (state_q == ST_POST) begin
            post_cnt_d = post_cnt_q - PTR_W'(1);
            if (post_cnt_q == PTR_W'(1)) state_d = ST_DONE;
          end
        end
      end
    endcase
  end

  // Control and status registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      cycle_count_q <= '0;
      post_cnt_q    <= '0;
      prev_pc_q     <= '0;
      prev_valid_q  <= 1'b0;
      triggered_q   <= 1'b0;
      halted_q      <= 1'b0;
      timed_out_q   <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
      cycle_count_q <= cycle_count_d;
      post_cnt_q    <= post_cnt_d;
      prev_pc_q     <= prev_pc_d;
      prev_valid_q  <= prev_valid_d;
      triggered_q   <= triggered_d;
      halted_q      <= halted_d;
      timed_out_q   <= timed_out_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // Trace storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (mem_we) trace_mem[wr_ptr_q] <= mem_wdata;
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.fill        = fill_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_POST);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.triggered   = triggered_q;
  assign bus.halted      = halted_q;
  assign bus.timed_out   = timed_out_q;
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb/tb_cpu_trace_monitor.sv - randomized self-checking bench for cpu_trace_monitor
module tb_cpu_trace_monitor;
  localparam int AW = 32, IW = 32, DEPTH = 16, POST_TRIG = 4, CW = 16, TIMEOUT = 24;
  localparam logic [31:0] HALT = 32'h0000000c;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cpu_trace_monitor_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

  cpu_trace_monitor #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG),
    .CNT_WIDTH(CW), .TIMEOUT(TIMEOUT), .HALT_INSTR(HALT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the trace is a queue keeping the newest DEPTH samples.
  logic [63:0] m_q[$];
  int          m_cnt;
  bit          m_busy, m_done, m_in_post, m_prev_valid, m_trig, m_halt, m_to;
  int          m_post_left;
  logic [31:0] m_prev_pc;

  task automatic model_reset();
    m_q.delete(); m_cnt = 0; m_busy = 0; m_done = 0; m_in_post = 0; m_prev_valid = 0;
    m_trig = 0; m_halt = 0; m_to = 0; m_post_left = 0; m_prev_pc = '0;
  endtask

  task automatic model_start();
    model_reset();
    m_busy = 1;
  endtask

  task automatic model_sample(input logic [31:0] p, input logic [31:0] ins);
    bit halt, to, trig;
    if (m_cnt < 65535) m_cnt++;
    m_q.push_back({p, ins});
    if (m_q.size() > DEPTH) void'(m_q.pop_front());
    halt = (ins == HALT) || (m_prev_valid && p == m_prev_pc);
    to   = (m_cnt == TIMEOUT);
    trig = !m_in_post && bus.trig_en && (p == bus.trig_pc);
    m_prev_pc = p; m_prev_valid = 1;
    m_halt |= halt; m_to |= to; m_trig |= trig;
    if (halt || to) begin
      m_busy = 0; m_done = 1;
    end else if (trig) begin
      if (POST_TRIG == 0) begin m_busy = 0; m_done = 1; end
      else begin m_in_post = 1; m_post_left = POST_TRIG; end
    end else if (m_in_post) begin
      m_post_left--;
      if (m_post_left == 0) begin m_busy = 0; m_done = 1; end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if (r == HALT) r = 32'h13;
    return r;
  endfunction

  task automatic cycle(input bit en, input logic [31:0] p, input logic [31:0] ins);
    bus.enable = en; bus.pc = p; bus.instruction = ins;
    if (en && m_busy) model_sample(p, ins);
    @(negedge clk);
    bus.enable = 1'b0;
  endtask

  // Start is given with enable=1 and a halt opcode: a wrongly taken sample would be visible.
  task automatic do_start();
    bus.start = 1'b1; bus.enable = 1'b1; bus.pc = $urandom; bus.instruction = HALT;
    if (!m_busy) model_start();
    @(negedge clk);
    bus.start = 1'b0; bus.enable = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.rd_data !== '0 || bus.rd_valid !== 1'b0 || bus.fill !== '0 || bus.cycle_count !== '0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.triggered !== 1'b0 || bus.halted !== 1'b0 ||
        bus.timed_out !== 1'b0)
      begin failures++; $display("FAIL reset_outputs got fill=%0d cnt=%0d busy=%b done=%b flags=%b%b%b rdv=%b want all zero",
        bus.fill, bus.cycle_count, bus.busy, bus.done, bus.triggered, bus.halted, bus.timed_out, bus.rd_valid); end
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_timeout();
    logic [31:0] p = 0;
    logic [63:0] e;
    bus.trig_en = 1'b0;
    do_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.cycle_count !== '0 || bus.fill !== '0) begin failures++;
      $display("FAIL start_state got busy=%b cnt=%0d fill=%0d want 1 0 0", bus.busy, bus.cycle_count, bus.fill); end
    for (int i = 0; i < 200 && m_busy; i++) begin
      bit en = ($urandom_range(0, 3) != 0);
      if (i == 5) bus.start = 1'b1;
      if (i == 6) bus.rd_en = 1'b1;
      cycle(en, p, rand_instr());
      bus.start = 1'b0;
      if (i == 6) begin
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rd_while_busy got rd_valid=%b want 0", bus.rd_valid); end
      end
      if (en) p += 4;
      checks++;
      if (bus.cycle_count !== m_cnt || bus.busy !== m_busy) begin failures++;
        $display("FAIL timeout_track got cnt=%0d busy=%b want %0d %b", bus.cycle_count, bus.busy, m_cnt, m_busy); end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.timed_out !== 1'b1 || bus.halted !== 1'b0 || bus.triggered !== 1'b0 ||
        bus.fill !== 5'd16 || bus.cycle_count !== 16'd24) begin failures++;
      $display("FAIL timeout_end got done=%b to=%b h=%b t=%b fill=%0d cnt=%0d want 1 1 0 0 16 24",
        bus.done, bus.timed_out, bus.halted, bus.triggered, bus.fill, bus.cycle_count); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e = m_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== e || (i == 0 && bus.rd_data[63:32] !== 32'h20)) begin failures++;
        $display("FAIL timeout_pop%0d got v=%b d=%h want 1 %h", i, bus.rd_valid, bus.rd_data, e); end
    end
    @(negedge clk);
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.fill !== '0) begin failures++;
      $display("FAIL pop_empty got v=%b fill=%0d want 0 0", bus.rd_valid, bus.fill); end
  endtask

  task automatic test_halt();
    logic [63:0] e;
    bus.trig_en = 1'b0;
    do_start();
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'(i * 4), (i == 19) ? HALT : rand_instr());
    checks++;
    if (bus.halted !== 1'b1 || bus.done !== 1'b1 || bus.timed_out !== 1'b0 || bus.fill !== 5'd16) begin failures++;
      $display("FAIL halt_end got h=%b done=%b to=%b fill=%0d want 1 1 0 16", bus.halted, bus.done, bus.timed_out, bus.fill); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e = m_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== e || (i == 0 && bus.rd_data[63:32] !== 32'h10) ||
          (i == 15 && bus.rd_data !== {32'h4c, HALT})) begin failures++;
        $display("FAIL halt_pop%0d got v=%b d=%h want 1 %h", i, bus.rd_valid, bus.rd_data, e); end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_trigger();
    logic [31:0] p = 0;
    logic [63:0] e;
    bit saw_post = 0;
    bus.trig_en = 1'b1; bus.trig_pc = 32'h20;
    do_start();
    for (int i = 0; i < 200 && m_busy; i++) begin
      bit en = ($urandom_range(0, 2) != 0);
      cycle(en, p, rand_instr());
      if (en) p += 4;
      if (m_in_post && m_busy) saw_post = 1;
      checks++;
      if (bus.busy !== m_busy || bus.triggered !== m_trig) begin failures++;
        $display("FAIL trig_track got busy=%b t=%b want %b %b", bus.busy, bus.triggered, m_busy, m_trig); end
    end
    bus.trig_en = 1'b0;
    checks++;
    if (!saw_post || bus.done !== 1'b1 || bus.triggered !== 1'b1 || bus.halted !== 1'b0 || bus.timed_out !== 1'b0 ||
        bus.fill !== 5'd13 || bus.cycle_count !== 16'd13) begin failures++;
      $display("FAIL trig_end got done=%b t=%b h=%b to=%b fill=%0d cnt=%0d want 1 1 0 0 13 13",
        bus.done, bus.triggered, bus.halted, bus.timed_out, bus.fill, bus.cycle_count); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      e = m_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== e || (i == 12 && bus.rd_data[63:32] !== 32'h30)) begin failures++;
        $display("FAIL trig_pop%0d got v=%b d=%h want 1 %h", i, bus.rd_valid, bus.rd_data, e); end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_coincide();
    bus.trig_en = 1'b0;
    do_start();
    cycle(1'b1, 32'h0, rand_instr());
    cycle(1'b1, 32'h4, rand_instr());
    cycle(1'b1, 32'h8, rand_instr());
    bus.trig_en = 1'b1; bus.trig_pc = 32'h8;
    cycle(1'b1, 32'h8, rand_instr());
    bus.trig_en = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.halted !== 1'b1 || bus.triggered !== 1'b1 || bus.fill !== 5'd4) begin
      failures++;
      $display("FAIL coincide got done=%b busy=%b h=%b t=%b fill=%0d want 1 0 1 1 4",
        bus.done, bus.busy, bus.halted, bus.triggered, bus.fill); end
  endtask

  task automatic test_drain_partial();
    int pulses = 0;
    logic [63:0] e;
    bus.trig_en = 1'b0;
    do_start();
    cycle(1'b1, 32'h100, rand_instr());
    bus.rd_en = 1'b1;
    cycle(1'b0, 32'h0, 32'h0);
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b1 || bus.fill !== 5'd1) begin failures++;
      $display("FAIL rd_in_run got v=%b busy=%b fill=%0d want 0 1 1", bus.rd_valid, bus.busy, bus.fill); end
    cycle(1'b1, 32'h104, rand_instr());
    cycle(1'b1, 32'h108, HALT);
    checks++;
    if (bus.fill !== 5'd3 || bus.done !== 1'b1) begin failures++;
      $display("FAIL drain_setup got fill=%0d done=%b want 3 1", bus.fill, bus.done); end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
        pulses++;
        e = (m_q.size() > 0) ? m_q.pop_front() : '0;
        checks++;
        if (bus.rd_data !== e) begin failures++; $display("FAIL drain_data%0d got %h want %h", i, bus.rd_data, e); end
      end
    end
    bus.rd_en = 1'b0;
    checks++;
    if (pulses != 3 || bus.fill !== '0) begin failures++;
      $display("FAIL drain_count got pulses=%0d fill=%0d want 3 0", pulses, bus.fill); end
  endtask

  task automatic test_reset_mid_post();
    bus.trig_en = 1'b1; bus.trig_pc = 32'h40;
    do_start();
    cycle(1'b1, 32'h38, rand_instr());
    cycle(1'b1, 32'h3c, rand_instr());
    cycle(1'b1, 32'h40, rand_instr());
    cycle(1'b1, 32'h44, rand_instr());
    checks++;
    if (bus.busy !== 1'b1 || bus.triggered !== 1'b1 || bus.done !== 1'b0) begin failures++;
      $display("FAIL in_post got busy=%b t=%b done=%b want 1 1 0", bus.busy, bus.triggered, bus.done); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_data !== '0 || bus.rd_valid !== 1'b0 || bus.fill !== '0 || bus.cycle_count !== '0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.triggered !== 1'b0 || bus.halted !== 1'b0 || bus.timed_out !== 1'b0)
      begin failures++; $display("FAIL async_reset got fill=%0d cnt=%0d busy=%b t=%b want all zero",
        bus.fill, bus.cycle_count, bus.busy, bus.triggered); end
    @(negedge clk); reset_n = 1'b1; model_reset();
    bus.trig_en = 1'b0;
    @(negedge clk);
    do_start();
    checks++;
    if (bus.cycle_count !== '0 || bus.triggered !== 1'b0 || bus.busy !== 1'b1) begin failures++;
      $display("FAIL restart got cnt=%0d t=%b busy=%b want 0 0 1", bus.cycle_count, bus.triggered, bus.busy); end
    cycle(1'b1, 32'h200, rand_instr());
    cycle(1'b1, 32'h204, rand_instr());
    checks++;
    if (bus.cycle_count !== 16'd2 || bus.fill !== 5'd2) begin failures++;
      $display("FAIL restart_count got cnt=%0d fill=%0d want 2 2", bus.cycle_count, bus.fill); end
    cycle(1'b1, 32'h208, HALT);
  endtask

  task automatic test_random();
    logic [31:0] p;
    logic [63:0] e;
    bit en, exp_v;
    for (int it = 0; it < 4; it++) begin
      bus.trig_en = 1'($urandom_range(0, 1));
      bus.trig_pc = 32'($urandom_range(0, 15) * 4);
      do_start();
      p = 32'($urandom_range(0, 15) * 4);
      for (int i = 0; i < 100 && m_busy; i++) begin
        if ($urandom_range(0, 9) != 0) p = 32'($urandom_range(0, 15) * 4);
        en = ($urandom_range(0, 3) != 0);
        cycle(en, p, ($urandom_range(0, 29) == 0) ? HALT : rand_instr());
        checks++;
        if (bus.fill !== m_q.size() || bus.cycle_count !== m_cnt || bus.busy !== m_busy || bus.done !== m_done ||
            bus.triggered !== m_trig || bus.halted !== m_halt || bus.timed_out !== m_to) begin failures++;
          $display("FAIL rand%0d_cap got fill=%0d cnt=%0d b=%b d=%b t%b h%b to%b want %0d %0d %b %b %b %b %b", it,
            bus.fill, bus.cycle_count, bus.busy, bus.done, bus.triggered, bus.halted, bus.timed_out,
            m_q.size(), m_cnt, m_busy, m_done, m_trig, m_halt, m_to); end
      end
      bus.trig_en = 1'b0;
      for (int i = 0; i < 100 && m_q.size() > 0; i++) begin
        en = 1'($urandom_range(0, 1));
        bus.rd_en = en; exp_v = en;
        e = en ? m_q.pop_front() : '0;
        @(negedge clk);
        checks++;
        if (bus.rd_valid !== exp_v || (exp_v && bus.rd_data !== e) || bus.fill !== m_q.size()) begin failures++;
          $display("FAIL rand%0d_pop got v=%b d=%h fill=%0d want %b %h %0d", it, bus.rd_valid, bus.rd_data,
            bus.fill, exp_v, e, m_q.size()); end
      end
      bus.rd_en = 1'b0;
      checks++;
      if (m_q.size() != 0 || bus.fill !== '0) begin failures++;
        $display("FAIL rand%0d_drain got fill=%0d left=%0d want 0 0", it, bus.fill, m_q.size()); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.enable = 1'b0; bus.pc = '0; bus.instruction = '0;
    bus.trig_en = 1'b0; bus.trig_pc = '0; bus.rd_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_timeout();
    test_halt();
    test_trigger();
    test_coincide();
    test_drain_partial();
    test_reset_mid_post();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
